uart_rsp_packer: RTL and testbench
==================================

Name: uart_rsp_packer

Overview:
- Transmit-side counterpart of the UART command receiver.
- Takes a read-response request (cmd, addr, size), fetches the requested words from the memory-mapped read port, and pushes a framed packet into the UART TX FIFO.
- Packet word order: CMD, SIZE, ADDR, then size+1 data words. This is the same framing the receiver parses.

Parameters:
- ADDR_STEP, 1, address increment added to the memory address after each data word.
- DW, 32, word width of FIFO, memory data and header fields. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- cmd_in  in  32  command word echoed as first packet word
- addr_in  in  32  start address of the read
- size_in  in  32  N; packet carries N+1 data words
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final word is accepted by the FIFO
- mem_rd_req  out  1  one-cycle read strobe
- mem_addr  out  32  read address, valid while mem_rd_req=1
- mem_rd_valid  in  1  read data valid, at least 1 cycle after mem_rd_req
- mem_rd_data  in  32  read data
- fifo_full  in  1  TX FIFO full
- fifo_write  out  1  FIFO write strobe (combinational, see below)
- fifo_data  out  32  FIFO write data

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - busy=0, done=0, mem_rd_req=0, mem_addr=0, fifo_data=0, fifo_write=0.
  - Internal count=0, latched cmd/addr/size=0.
  - Any reset mid-packet abandons the packet with no further FIFO writes.
- States: IDLE, H_CMD, H_SIZE, H_ADDR, RD_REQ, RD_WAIT, D_PUSH, (C_PUSH), FIN.
- IDLE:
  - If start=1: latch cmd_in, addr_in, size_in; clear count; set busy=1; go to H_CMD.
  - start in any other state is ignored. It is neither queued nor latched.
- Push states (H_CMD, H_SIZE, H_ADDR, D_PUSH, C_PUSH):
  - fifo_data = word for that state.
  - fifo_write = !fifo_full, combinationally.
  - A word is accepted on a rising edge with fifo_write=1. The state advances only then.
  - While fifo_full=1, stay in the state with fifo_data held stable.
  - Never write while fifo_full=1.
- Header sequence: H_CMD pushes cmd, then H_SIZE pushes size, then H_ADDR pushes addr, then go to RD_REQ.
- RD_REQ:
  - mem_rd_req=1 for exactly one cycle, with mem_addr = current address.
  - Go to RD_WAIT.
- RD_WAIT:
  - Wait for mem_rd_valid=1, then capture mem_rd_data.
  - Go to D_PUSH.
  - mem_rd_valid outside RD_WAIT is ignored.
- D_PUSH, on acceptance:
  - address += ADDR_STEP (mod 2^32).
  - If count == size: go to FIN (or C_PUSH when the optional feature is enabled).
  - Else: count += 1 and return to RD_REQ.
- FIN: done=1 for one cycle, busy=0, return to IDLE. A new start is honoured the cycle after FIN.
- Only one memory read is outstanding at a time. There is no prefetch.
- Best-case throughput: 3 cycles per data word (RD_REQ, RD_WAIT with 1-cycle latency, D_PUSH).
- Boundaries:
  - size=0 gives exactly one data word.
  - size=0xFFFFFFFF is legal; the count is 32-bit and the comparison is by equality.
  - Address wraps from 0xFFFFFFFF to 0.
  - fifo_full may toggle on any cycle, including during header words.

Optional Feature:
- Macro: UARTRSP_CHECKSUM_EN.
- Defined:
  - A 32-bit running XOR of all accepted data words is kept, cleared on start.
  - After the last data word, state C_PUSH pushes the XOR as a trailer word, then goes to FIN.
  - Packet length = N+5 words.
- Undefined: no trailer and no checksum register. Packet length = N+4 words.

Test Plan:
- Basic packet:
  - Stimulus: start with cmd=0x00000002, addr=0x100, size=1. Memory returns 0xAAAA0001 and 0xAAAA0002 with 1-cycle latency. FIFO never full.
  - Response: FIFO receives 0x2, 0x1, 0x100, 0xAAAA0001, 0xAAAA0002. mem_addr sequence is 0x100, 0x101. done pulses once.
- Backpressure:
  - Stimulus: same as basic packet, with fifo_full=1 for 5 cycles during H_SIZE and for 3 cycles during the second D_PUSH.
  - Response: no fifo_write while full. fifo_data is held. The same 5 words arrive in order.
- Single word and address wrap:
  - Stimulus: size=0, addr=0xFFFFFFFF, ADDR_STEP=1.
  - Response: exactly one data word and one mem_rd_req at 0xFFFFFFFF. done follows.
  - A second start with size=1 at addr=0xFFFFFFFF gives reads at 0xFFFFFFFF then 0x0.
- Start ignored while busy:
  - Stimulus: pulse start again in RD_WAIT with different fields.
  - Response: the packet is unchanged. No second packet follows.
- Reset mid-operation:
  - Stimulus: assert reset during D_PUSH of word 2 of 4.
  - Response: all outputs 0 immediately. No further FIFO writes. A subsequent start produces a complete, correct packet.
- Checksum (UARTRSP_CHECKSUM_EN):
  - Stimulus: data words 0x0F0F0000, 0x00F0F0F0.
  - Response: trailer 0x0FFFF0F0 after the data; 6 words total.

Source files
------------

// File: rtl/uart_rsp_packer_if.sv
// Handshake and bus bundle for uart_rsp_packer: request fields, status,
// memory read port and UART TX FIFO write port.
interface uart_rsp_packer_if #(
    parameter int unsigned DW = 32
);
    logic          start;
    logic [DW-1:0] cmd_in;
    logic [DW-1:0] addr_in;
    logic [DW-1:0] size_in;
    logic          busy;
    logic          done;
    logic          mem_rd_req;
    logic [DW-1:0] mem_addr;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic          fifo_full;
    logic          fifo_write;
    logic [DW-1:0] fifo_data;

    // Packer side
    modport slave (
        input  start, cmd_in, addr_in, size_in,
        input  mem_rd_valid, mem_rd_data, fifo_full,
        output busy, done, mem_rd_req, mem_addr, fifo_write, fifo_data
    );

    // Requester / memory / FIFO side
    modport master (
        output start, cmd_in, addr_in, size_in,
        output mem_rd_valid, mem_rd_data, fifo_full,
        input  busy, done, mem_rd_req, mem_addr, fifo_write, fifo_data
    );
endinterface

// File: rtl/uart_rsp_packer.sv
// UART read-response packer: frames CMD, SIZE, ADDR and size+1 memory words into the TX FIFO.
// Optional XOR trailer word when UARTRSP_CHECKSUM_EN is defined.
module uart_rsp_packer #(
    parameter int unsigned ADDR_STEP = 1,
    parameter int unsigned DW        = 32
) (
    input  logic             clk,
    input  logic             reset,
    uart_rsp_packer_if.slave bus
);
    localparam int unsigned W = DW;

    typedef enum logic [3:0] {
        IDLE,
        H_CMD,
        H_SIZE,
        H_ADDR,
        RD_REQ,
        RD_WAIT,
        D_PUSH,
`ifdef UARTRSP_CHECKSUM_EN
        C_PUSH,
`endif
        FIN
    } state_t;

    state_t         state_q, state_n;
    logic [W-1:0]   addr_q, addr_n;
    logic [W-1:0]   size_q, size_n;
    logic [W-1:0]   count_q, count_n;
    logic [W-1:0]   data_q, data_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;
    logic           rd_req_q, rd_req_n;
    logic           push_c;
    logic           fifo_write_c;
`ifdef UARTRSP_CHECKSUM_EN
    logic [W-1:0]   csum_q, csum_n;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            count_q  <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_req_q <= 1'b0;
`ifdef UARTRSP_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_n;
            addr_q   <= addr_n;
            size_q   <= size_n;
            count_q  <= count_n;
            data_q   <= data_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            rd_req_q <= rd_req_n;
`ifdef UARTRSP_CHECKSUM_EN
            csum_q   <= csum_n;
`endif
        end
    end

    // Push states present a word; it is accepted on any edge where the FIFO is not full
    always_comb begin
        push_c = 1'b0;
        case (state_q)
            H_CMD, H_SIZE, H_ADDR, D_PUSH: push_c = 1'b1;
`ifdef UARTRSP_CHECKSUM_EN
            C_PUSH:                        push_c = 1'b1;
`endif
            default:                       push_c = 1'b0;
        endcase
        fifo_write_c = push_c & ~bus.fifo_full;
    end

    // Next-state logic; data_q is loaded with the word of the push state being entered
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        size_n  = size_q;
        count_n = count_q;
        data_n  = data_q;
`ifdef UARTRSP_CHECKSUM_EN
        csum_n  = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_n  = bus.cmd_in;
                    addr_n  = bus.addr_in;
                    size_n  = bus.size_in;
                    count_n = '0;
`ifdef UARTRSP_CHECKSUM_EN
                    csum_n  = '0;
`endif
                    state_n = H_CMD;
                end
            end
            H_CMD: begin
                if (fifo_write_c) begin
                    data_n  = size_q;
                    state_n = H_SIZE;
                end
            end
            H_SIZE: begin
                if (fifo_write_c) begin
                    data_n  = addr_q;
                    state_n = H_ADDR;
                end
            end
            H_ADDR: begin
                if (fifo_write_c) state_n = RD_REQ;
            end
            RD_REQ: begin
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_rd_valid) begin
                    data_n  = bus.mem_rd_data;
                    state_n = D_PUSH;
                end
            end
            D_PUSH: begin
                if (fifo_write_c) begin
                    addr_n = addr_q + W'(ADDR_STEP);
`ifdef UARTRSP_CHECKSUM_EN
                    csum_n = csum_q ^ data_q;
`endif
                    if (count_q == size_q) begin
`ifdef UARTRSP_CHECKSUM_EN
                        data_n  = csum_n;
                        state_n = C_PUSH;
`else
                        state_n = FIN;
`endif
                    end else begin
                        count_n = count_q + W'(1);
                        state_n = RD_REQ;
                    end
                end
            end
`ifdef UARTRSP_CHECKSUM_EN
            C_PUSH: begin
                if (fifo_write_c) state_n = FIN;
            end
`endif
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n   = (state_n != IDLE) && (state_n != FIN);
        done_n   = (state_n == FIN);
        rd_req_n = (state_n == RD_REQ);
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mem_rd_req = rd_req_q;
    assign bus.mem_addr   = addr_q;
    assign bus.fifo_write = fifo_write_c;
    assign bus.fifo_data  = data_q;

endmodule

// File: tb/tb_uart_rsp_packer.sv
// Self-checking bench for uart_rsp_packer: directed and randomized packets against a packet-level model.
// Honours UARTRSP_CHECKSUM_EN for the optional XOR trailer.
module tb_uart_rsp_packer;
    localparam int unsigned DW   = 32;
    localparam logic [31:0] STEP = 32'd1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rsp_packer_if #(.DW(DW)) bus();

    uart_rsp_packer #(.ADDR_STEP(1), .DW(DW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_q[$];
    logic [31:0] rd_addr_q[$];
    logic [31:0] rd_data_q[$];
    logic [31:0] preload_q[$];
    int          done_cnt = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // FIFO / done monitor, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (bus.fifo_write === 1'b1) got_q.push_back(bus.fifo_data);
            if (bus.done === 1'b1) done_cnt++;
            check("write_while_full", {31'b0, bus.fifo_write & bus.fifo_full}, 32'd0);
        end
    end

    // Memory responder: one read at a time, latency lat_min..lat_max cycles
    initial begin
        logic [31:0] d;
        int          lat;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (bus.mem_rd_req === 1'b1 && rst_n === 1'b1) begin
                rd_addr_q.push_back(bus.mem_addr);
                if (preload_q.size() > 0) d = preload_q.pop_front();
                else                      d = $urandom;
                rd_data_q.push_back(d);
                lat = $urandom_range(lat_max, lat_min);
                repeat (lat) @(posedge clk);
                #1;
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = d;
                @(posedge clk);
                #1;
                bus.mem_rd_valid = 1'b0;
                bus.mem_rd_data  = $urandom;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bp: 0 never full, 1 random, 2 directed stalls; inj: 0 none, 1 random, 2 every busy cycle
    task automatic run_pkt(input logic [31:0] cmd, input logic [31:0] addr, input logic [31:0] size,
                           input int bp, input int inj, input string name);
        int          g0, r0, d0, acc, cyc, h_stall, d_stall, n;
        logic [31:0] exp_q[$];
        logic [31:0] x;
        g0 = got_q.size(); r0 = rd_addr_q.size(); d0 = done_cnt;
        h_stall = 0; d_stall = 0; cyc = 0;
        bus.start = 1'b1; bus.cmd_in = cmd; bus.addr_in = addr; bus.size_in = size;
        step();
        bus.start = 1'b0; bus.cmd_in = $urandom; bus.addr_in = $urandom; bus.size_in = $urandom;
        check({name, ":busy_after_start"}, {31'b0, bus.busy}, 32'd1);
        check({name, ":cmd_presented"}, bus.fifo_data, cmd);
        while (done_cnt == d0 && cyc < 3000) begin
            acc = got_q.size() - g0;
            bus.fifo_full = 1'b0;
            if (bp == 1) bus.fifo_full = ($urandom_range(2, 0) == 0);
            else if (bp == 2) begin
                if (acc == 1 && h_stall < 5)      begin bus.fifo_full = 1'b1; h_stall++; end
                else if (acc == 4 && d_stall < 5) begin bus.fifo_full = 1'b1; d_stall++; end
            end
            bus.start = 1'b0;
            if (bus.busy === 1'b1 && (inj == 2 || (inj == 1 && $urandom_range(3, 0) == 0))) begin
                bus.start = 1'b1; bus.cmd_in = $urandom; bus.addr_in = $urandom;
                bus.size_in = $urandom_range(7, 0);
            end
            @(negedge clk);
            if (bp == 2 && bus.fifo_full === 1'b1) begin
                check({name, ":stall_no_write"}, {31'b0, bus.fifo_write}, 32'd0);
                if (acc == 1) check({name, ":size_held"}, bus.fifo_data, size);
                if (acc == 4 && d_stall >= 3) check({name, ":data_held"}, bus.fifo_data, rd_data_q[r0+1]);
            end
            step();
            cyc++;
        end
        bus.start = 1'b0; bus.fifo_full = 1'b0;
        check({name, ":done_seen"}, {31'b0, done_cnt != d0}, 32'd1);
        check({name, ":done_one_cycle"}, {31'b0, bus.done}, 32'd0);
        check({name, ":idle_not_busy"}, {31'b0, bus.busy}, 32'd0);
        repeat (10) step();
        check({name, ":done_count"}, 32'(done_cnt - d0), 32'd1);

        // Reference packet from the request fields and the data the memory model supplied
        n = int'(size) + 1;
        exp_q.push_back(cmd); exp_q.push_back(size); exp_q.push_back(addr);
        x = '0;
        for (int i = 0; i < n && (r0 + i) < rd_data_q.size(); i++) begin
            exp_q.push_back(rd_data_q[r0+i]);
            x ^= rd_data_q[r0+i];
        end
`ifdef UARTRSP_CHECKSUM_EN
        exp_q.push_back(x);
        check({name, ":pkt_len"}, 32'(got_q.size() - g0), 32'(n + 4));
`else
        check({name, ":pkt_len"}, 32'(got_q.size() - g0), 32'(n + 3));
`endif
        check({name, ":rd_count"}, 32'(rd_addr_q.size() - r0), 32'(n));
        for (int i = 0; i < exp_q.size() && (g0 + i) < got_q.size(); i++)
            check($sformatf("%s:word%0d", name, i), got_q[g0+i], exp_q[i]);
        for (int i = 0; i < n && (r0 + i) < rd_addr_q.size(); i++)
            check($sformatf("%s:rd_addr%0d", name, i), rd_addr_q[r0+i], addr + 32'(i) * STEP);
    endtask

    initial begin
        int g0, d0, cyc;
        bus.start = 1'b0; bus.cmd_in = '0; bus.addr_in = '0; bus.size_in = '0;
        bus.fifo_full = 1'b0;
        repeat (3) step();
        check("rst:busy",       {31'b0, bus.busy},       32'd0);
        check("rst:done",       {31'b0, bus.done},       32'd0);
        check("rst:mem_rd_req", {31'b0, bus.mem_rd_req}, 32'd0);
        check("rst:mem_addr",   bus.mem_addr,            32'd0);
        check("rst:fifo_data",  bus.fifo_data,           32'd0);
        check("rst:fifo_write", {31'b0, bus.fifo_write}, 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        preload_q = '{32'hAAAA_0001, 32'hAAAA_0002};
        run_pkt(32'h2, 32'h100, 32'd1, 0, 0, "basic");
        check("basic:d0", got_q[3], 32'hAAAA_0001);
        check("basic:d1", got_q[4], 32'hAAAA_0002);

        preload_q = '{32'hAAAA_0001, 32'hAAAA_0002};
        run_pkt(32'h2, 32'h100, 32'd1, 2, 0, "bp");

        run_pkt(32'h7, 32'hFFFF_FFFF, 32'd0, 0, 0, "wrap0");
        run_pkt(32'h8, 32'hFFFF_FFFF, 32'd1, 0, 0, "wrap1");
        check("wrap1:second_addr", rd_addr_q[rd_addr_q.size()-1], 32'h0);

        lat_min = 3; lat_max = 4;
        run_pkt(32'h9, 32'h40, 32'd2, 0, 2, "ignore_start");
        lat_min = 1; lat_max = 1;

        // Reset while the second of four data words is stalled in D_PUSH
        g0 = got_q.size(); d0 = done_cnt; cyc = 0;
        bus.start = 1'b1; bus.cmd_in = 32'h5; bus.addr_in = 32'h200; bus.size_in = 32'd3;
        step();
        bus.start = 1'b0;
        while (got_q.size() - g0 < 4 && cyc < 200) begin step(); cyc++; end
        check("rstmid:reached_d1", 32'(got_q.size() - g0), 32'd4);
        bus.fifo_full = 1'b1;
        repeat (3) step();
        check("rstmid:stalled_data", bus.fifo_data, rd_data_q[rd_data_q.size()-1]);
        rst_n = 1'b0;
        #1;
        check("rstmid:busy",       {31'b0, bus.busy},       32'd0);
        check("rstmid:done",       {31'b0, bus.done},       32'd0);
        check("rstmid:mem_rd_req", {31'b0, bus.mem_rd_req}, 32'd0);
        check("rstmid:mem_addr",   bus.mem_addr,            32'd0);
        check("rstmid:fifo_data",  bus.fifo_data,           32'd0);
        check("rstmid:fifo_write", {31'b0, bus.fifo_write}, 32'd0);
        bus.fifo_full = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        check("rstmid:no_more_writes", 32'(got_q.size() - g0), 32'd4);
        check("rstmid:no_done", 32'(done_cnt - d0), 32'd0);
        run_pkt(32'h6, 32'h300, 32'd3, 0, 0, "after_rst");

`ifdef UARTRSP_CHECKSUM_EN
        preload_q = '{32'h0F0F_0000, 32'h00F0_F0F0};
        g0 = got_q.size();
        run_pkt(32'h3, 32'h500, 32'd1, 0, 0, "csum");
        check("csum:trailer", got_q[g0+5], 32'h0FFF_F0F0);
`endif

        lat_min = 1; lat_max = 4;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] a;
            a = (k % 3 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3, 0))) : $urandom;
            run_pkt($urandom, a, 32'($urandom_range(5, 0)), 1, 1, $sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
